// File: rtl/dcache_wb_if.sv
// dcache_wb_if: single-word memory port between the data cache and memory.
//   master (cache)  : drives mem_req, mem_we, mem_addr, mem_wdata; samples mem_ack, mem_rdata
//   slave  (memory) : the reverse
// One beat per request; mem_ack may be asserted in the same cycle as mem_req.
interface dcache_wb_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache between the
// MEM stage and a single-word memory port.
//   clk, rst        clock; synchronous active-high reset
//   i_pipeline_en   pipeline advancing; hit accesses commit only when high
//   i_ren, i_wen    load / store request (both high = store)
//   i_addr          byte address
//   i_rwidth/i_rsign load width (0 byte, 1 half, else word) and sign extension
//   i_wwidth/i_wdata store width and right-aligned store data
//   o_rdata         registered load result
//   o_valid         combinational; low = stall the pipeline
//   mem             memory beat port (master side)
//
// state    | meaning
// S_IDLE   | serving hits; a miss starts WB or REFILL on the next edge
// S_WB     | writing the dirty victim line out, one word per beat
// S_REFILL | reading the requested line in, one word per beat
module dcache_wb #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pipeline_en,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_rwidth,
  input  logic              i_rsign,
  output logic [31:0]       o_rdata,
  input  logic              i_wen,
  input  logic [2:0]        i_wwidth,
  input  logic [31:0]       i_wdata,
  output logic              o_valid,
  dcache_wb_if.master       mem
);

  localparam int OFF   = $clog2(LINE_WORDS * 4);
  localparam int IDX   = $clog2(SETS);
  localparam int WOFF  = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - OFF - IDX;
  localparam logic [WOFF-1:0] LAST = WOFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS*LINE_WORDS];

  state_t            r_state, w_state_nxt;
  logic [WOFF-1:0]   r_beat, w_beat_nxt;
  logic              r_mem_req, w_req_nxt;
  logic              r_mem_we, w_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [31:0]       r_mem_wdata, w_wdata_nxt;
  logic [31:0]       r_rdata;

  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [WOFF-1:0]  w_word;
  logic [WOFF-1:0]  w_beat_inc;
  logic [31:0]      w_rword;
  logic             w_hit;
  logic             w_miss_start;
  logic             w_fill_done;
  logic             w_ld_commit;
  logic             w_st_commit;
  logic [31:0]      w_load;
  logic [3:0]       w_be;
  logic [31:0]      w_wd;
  logic [31:0]      w_merged;

  assign w_idx      = i_addr[OFF+IDX-1:OFF];
  assign w_tag      = i_addr[ADDR_W-1:OFF+IDX];
  assign w_word     = i_addr[OFF-1:2];
  assign w_beat_inc = r_beat + 1'b1;
  assign w_rword    = r_data[{w_idx, w_word}];

  assign w_hit        = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign o_valid      = !(i_ren || i_wen) || w_hit;
  assign w_miss_start = (r_state == S_IDLE) && (i_ren || i_wen) && !w_hit;
  assign w_fill_done  = (r_state == S_REFILL) && mem.mem_ack && (r_beat == LAST);
  assign w_ld_commit  = i_pipeline_en && w_hit && i_ren && !i_wen;
  assign w_st_commit  = i_pipeline_en && w_hit && i_wen;

  // Load lane extraction; half ignores addr[0], word ignores addr[1:0].
  always_comb begin
    w_load = w_rword;
    case (i_rwidth)
      3'd0: begin
        w_load[7:0]  = w_rword[{i_addr[1:0], 3'b000} +: 8];
        w_load[31:8] = {24{i_rsign & w_load[7]}};
      end
      3'd1: begin
        w_load[15:0]  = w_rword[{i_addr[1], 4'b0000} +: 16];
        w_load[31:16] = {16{i_rsign & w_load[15]}};
      end
      default: w_load = w_rword;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be = 4'b1111;
    w_wd = i_wdata;
    case (i_wwidth)
      3'd0: begin
        w_be = 4'b0001 << i_addr[1:0];
        w_wd = {4{i_wdata[7:0]}};
      end
      3'd1: begin
        w_be = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = i_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      w_merged[8*b +: 8] = w_be[b] ? w_wd[8*b +: 8] : w_rword[8*b +: 8];
    end
  end

  // Next beat is computed here and registered, so the port is stable until acked.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_miss_start) begin
          w_beat_nxt = '0;
          w_req_nxt  = 1'b1;
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_state_nxt = S_WB;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = {r_tag[w_idx], w_idx, {WOFF{1'b0}}, 2'b00};
            w_wdata_nxt = r_data[{w_idx, {WOFF{1'b0}}}];
          end else begin
            w_state_nxt = S_REFILL;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = {w_tag, w_idx, {WOFF{1'b0}}, 2'b00};
            w_wdata_nxt = '0;
          end
        end
      end
      S_WB: begin
        if (mem.mem_ack) begin
          if (r_beat == LAST) begin
            w_state_nxt = S_REFILL;
            w_beat_nxt  = '0;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = {w_tag, w_idx, {WOFF{1'b0}}, 2'b00};
            w_wdata_nxt = '0;
          end else begin
            w_beat_nxt  = w_beat_inc;
            w_addr_nxt  = {r_tag[w_idx], w_idx, w_beat_inc, 2'b00};
            w_wdata_nxt = r_data[{w_idx, w_beat_inc}];
          end
        end
      end
      S_REFILL: begin
        if (mem.mem_ack) begin
          if (r_beat == LAST) begin
            w_state_nxt = S_IDLE;
            w_beat_nxt  = '0;
            w_req_nxt   = 1'b0;
            w_we_nxt    = 1'b0;
          end else begin
            w_beat_nxt = w_beat_inc;
            w_addr_nxt = {w_tag, w_idx, w_beat_inc, 2'b00};
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  // The line is invalidated as the miss starts, so an aborted burst leaves it invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_miss_start) r_valid[w_idx] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_st_commit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) r_tag[w_idx] <= w_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((r_state == S_REFILL) && mem.mem_ack) r_data[{w_idx, r_beat}] <= mem.mem_rdata;
      else if (w_st_commit)                     r_data[{w_idx, w_word}] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_rdata <= '0;
    else if (w_ld_commit) r_rdata <= w_load;
  end

  assign o_rdata       = r_rdata;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed test of dcache_wb with a scoreboard. Expected memory
// beats and load results are queued by the stimulus; the memory responder and
// the load monitor pop and compare as the DUT produces them.
module tb_dcache_wb;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe, ren, wen, rsign;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  rwidth, wwidth;
  logic        valid;

  dcache_wb_if #(.ADDR_W(32)) bus ();

  dcache_wb #(.SETS(64), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pipeline_en (pe),
    .i_ren         (ren),
    .i_addr        (addr),
    .i_rwidth      (rwidth),
    .i_rsign       (rsign),
    .o_rdata       (rdata),
    .i_wen         (wen),
    .i_wwidth      (wwidth),
    .i_wdata       (wdata),
    .o_valid       (valid),
    .mem           (bus.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          max_delay = 0;
  int          req_cycles = 0;
  int          rd_ack_seen = 0;
  logic [31:0] mem [1024];
  beat_t       exp_beat [$];
  logic [31:0] exp_rd [$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_beats(input bit we, input logic [31:0] base, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.we = we; b.addr = base + 32'(4 * i); b.data = d[i];
      exp_beat.push_back(b);
    end
  endtask

  // Present one access, wait (bounded) for valid, then commit it for one cycle.
  task automatic access(input logic [31:0] a, input bit r, input bit w, input logic [2:0] width,
                        input bit sg, input logic [31:0] wd, input logic [31:0] exp);
    int n;
    @(negedge clk);
    addr = a; ren = r; wen = w; rwidth = width; wwidth = width; rsign = sg; wdata = wd; pe = 1'b0;
    #1;
    n = 0;
    while (!valid && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check32("stall_bound", {31'd0, valid}, 32'd1);
    if (valid) begin
      if (r && !w) exp_rd.push_back(exp);
      pe = 1'b1;
      @(negedge clk);
    end
    pe = 1'b0; ren = 1'b0; wen = 1'b0;
  endtask

  // Memory responder and beat monitor.
  initial begin : responder
    bit          pending;
    int          cnt;
    beat_t       held;
    beat_t       e;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i << 2);
    mem[32'h100 >> 2] = 32'h000080FF;
    mem[32'h104 >> 2] = 32'h11111111;
    mem[32'h108 >> 2] = 32'h22222222;
    mem[32'h10C >> 2] = 32'h33333333;
    for (int i = 0; i < 4; i++) mem[(32'h500 >> 2) + i] = 32'h55550000 + 32'(4 * i);
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    pending = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst || !bus.mem_req) begin
        pending = 1'b0;
      end else begin
        req_cycles++;
        if (!pending) begin
          pending = 1'b1;
          cnt = $urandom_range(0, max_delay);
          held.we = bus.mem_we; held.addr = bus.mem_addr; held.data = bus.mem_wdata;
          if (exp_beat.size() == 0) begin
            checks++; failures++;
            $display("FAIL beat_unexpected got_addr=%h exp=none", bus.mem_addr);
          end else begin
            e = exp_beat.pop_front();
            check32("beat_we_addr", {bus.mem_we, bus.mem_addr[30:0]}, {e.we, e.addr[30:0]});
            if (e.we) check32("beat_wdata", bus.mem_wdata, e.data);
          end
        end else begin
          check32("beat_stable_addr", bus.mem_addr, held.addr);
          check32("beat_stable_wdata", bus.mem_wdata, held.data);
        end
        if (cnt == 0) begin
          bus.mem_ack = 1'b1;
          pending = 1'b0;
          if (bus.mem_we) begin
            mem[bus.mem_addr[11:2]] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem[bus.mem_addr[11:2]];
            rd_ack_seen++;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Load monitor: a load committed at a posedge is checked at the following negedge.
  initial begin : load_monitor
    bit committed;
    committed = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (committed) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdata_unexpected got=%h exp=none", rdata);
        end else begin
          check32("rdata", rdata, exp_rd.pop_front());
        end
      end
      committed = pe && valid && ren && !wen && !rst;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int snap;
    rst = 1'b1; pe = 1'b0; ren = 1'b0; wen = 1'b0; rsign = 1'b0;
    addr = '0; wdata = '0; rwidth = 3'd2; wwidth = 3'd2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check32("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check32("reset_valid_idle", {31'd0, valid}, 32'd1);

    // Cold miss
    @(negedge clk);
    addr = 32'h100; ren = 1'b1; rwidth = 3'd2;
    #1;
    check32("cold_miss_valid", {31'd0, valid}, 32'd0);
    push_beats(1'b0, 32'h100, 0, 0, 0, 0);
    access(32'h100, 1, 0, 3'd2, 0, 0, 32'h000080FF);

    // Extension
    access(32'h101, 1, 0, 3'd0, 1, 0, 32'hFFFFFF80);
    access(32'h101, 1, 0, 3'd0, 0, 0, 32'h00000080);
    access(32'h102, 1, 0, 3'd1, 1, 0, 32'h00000000);
    access(32'h100, 1, 0, 3'd1, 1, 0, 32'hFFFF80FF);
    access(32'h100, 1, 0, 3'd0, 0, 0, 32'h000000FF);
    access(32'h104, 1, 0, 3'd7, 0, 0, 32'h11111111);

    // Store hits, no memory traffic
    snap = req_cycles;
    access(32'h103, 0, 1, 3'd0, 0, 32'h000000AB, 0);
    access(32'h100, 1, 0, 3'd2, 0, 0, 32'hAB0080FF);
    access(32'h107, 1, 1, 3'd1, 0, 32'h1234BEEF, 0);
    access(32'h104, 1, 0, 3'd2, 0, 0, 32'hBEEF1111);
    check32("store_hit_no_mem", 32'(req_cycles - snap), 32'd0);

    // Dirty conflict with backpressure
    max_delay = 5;
    push_beats(1'b1, 32'h100, 32'hAB0080FF, 32'hBEEF1111, 32'h22222222, 32'h33333333);
    push_beats(1'b0, 32'h500, 0, 0, 0, 0);
    access(32'h500, 1, 0, 3'd2, 0, 0, 32'h55550000);
    access(32'h50C, 1, 0, 3'd2, 0, 0, 32'h5555000C);
    push_beats(1'b0, 32'h100, 0, 0, 0, 0);
    access(32'h100, 1, 0, 3'd2, 0, 0, 32'hAB0080FF);

    // pipeline_en low: hits change nothing
    snap = req_cycles;
    @(negedge clk);
    addr = 32'h104; ren = 1'b1; rwidth = 3'd2; pe = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check32("hold_rdata", rdata, 32'hAB0080FF);
    check32("hold_valid", {31'd0, valid}, 32'd1);
    @(negedge clk);
    addr = 32'h108; ren = 1'b0; wen = 1'b1; wwidth = 3'd2; wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    wen = 1'b0;
    check32("hold_no_mem", 32'(req_cycles - snap), 32'd0);
    access(32'h108, 1, 0, 3'd2, 0, 0, 32'h22222222);

    // Store miss allocates the line
    push_beats(1'b0, 32'h200, 0, 0, 0, 0);
    access(32'h208, 0, 1, 3'd2, 0, 32'h12345678, 0);
    access(32'h208, 1, 0, 3'd2, 0, 0, 32'h12345678);
    access(32'h20C, 1, 0, 3'd2, 0, 0, 32'hC0DE020C);

    // Reset during the second refill ack
    max_delay = 0;
    @(negedge clk);
    rd_ack_seen = 0;
    push_beats(1'b0, 32'h300, 0, 0, 0, 0);
    addr = 32'h300; ren = 1'b1; rwidth = 3'd2; pe = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(bus.mem_ack && rd_ack_seen == 2) && n < 100);
    check32("second_ack_seen", 32'(rd_ack_seen), 32'd2);
    rst = 1'b1; ren = 1'b0;
    @(posedge clk); #1;
    check32("rst_abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_beat.delete();
    push_beats(1'b0, 32'h100, 0, 0, 0, 0);
    access(32'h100, 1, 0, 3'd2, 0, 0, 32'hAB0080FF);
    push_beats(1'b0, 32'h300, 0, 0, 0, 0);
    access(32'h300, 1, 0, 3'd2, 0, 0, 32'hC0DE0300);

    repeat (3) @(negedge clk);
    check32("beats_drained", 32'(exp_beat.size()), 32'd0);
    check32("loads_drained", 32'(exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
